// File: rtl/video_timing_ctrl_if.sv
// Line-fetch handshake between the timing sequencer (master) and the
// upstream line buffer (slave).
interface video_timing_ctrl_if;
    logic        line_req;
    logic [11:0] line_num;
    logic        line_ack;

    modport master (output line_req, output line_num, input line_ack);
    modport slave  (input line_req, input line_num, output line_ack);
endinterface

// File: rtl/video_timing_ctrl.sv
// Pixel-domain timing sequencer: sync/DE/coordinate generation with
// frame-aligned start/stop and per-line prefetch requests.
module video_timing_ctrl #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int SYNC_POL = 1,
    parameter int PREFETCH = 64
) (
    input  logic                       hdmi_clk,
    input  logic                       reset,
    input  logic                       enable_i,
    output logic                       hsync_o,
    output logic                       vsync_o,
    output logic                       de_o,
    output logic [11:0]                x_o,
    output logic [11:0]                y_o,
    output logic                       frame_start_o,
    output logic                       underflow_o,
    output logic                       running_o,
    video_timing_ctrl_if.master        line_if
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] H_REQ  = 12'(H_TOTAL - PREFETCH);
    localparam logic SYNC_ON  = (SYNC_POL != 0);
    localparam logic SYNC_OFF = !SYNC_ON;

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_STOP} state_e;

    state_e      state_q, state_d;
    logic [11:0] h_q, h_d, v_q, v_d;
    logic [11:0] num_q, num_d;
    logic        req_q, req_d;
    logic        unf_q, unf_d;

    logic        h_wrap, ack_ok, active_d, new_req;
    logic [11:0] h_inc, v_inc, n_d;

    always_comb begin
        ack_ok  = req_q && line_if.line_ack;
        h_wrap  = (h_q == H_LAST);
        h_inc   = h_wrap ? 12'd0 : h_q + 12'd1;
        v_inc   = v_q;
        if (h_wrap) v_inc = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;

        state_d = state_q;
        h_d     = 12'd0;
        v_d     = 12'd0;
        case (state_q)
            S_IDLE:  if (enable_i) state_d = S_PRIME;
            S_PRIME: begin
                if (!enable_i)   state_d = S_IDLE;
                else if (ack_ok) state_d = S_RUN;
            end
            S_RUN: begin
                h_d = h_inc;
                v_d = v_inc;
                if (!enable_i) state_d = S_STOP;
            end
            S_STOP: begin
                // Ending on the last pixel leaves the counters at 0,0 for IDLE.
                h_d = h_inc;
                v_d = v_inc;
                if (enable_i)                      state_d = S_RUN;
                else if (h_wrap && v_q == V_LAST)  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        active_d = (state_d == S_RUN) || (state_d == S_STOP);
        n_d      = (v_d == V_LAST) ? 12'd0 : v_d + 12'd1;
        new_req  = active_d && (h_d == H_REQ) && (n_d < V_ACT) &&
                   !((state_d == S_STOP) && (n_d == 12'd0));

        req_d = req_q;
        num_d = num_q;
        unf_d = unf_q;
        if (ack_ok) begin
            req_d = 1'b0;
        end else if (req_q && h_wrap && (state_q == S_RUN || state_q == S_STOP)) begin
            req_d = 1'b0;
            unf_d = 1'b1;
        end
        if (state_q == S_IDLE && enable_i) begin
            req_d = 1'b1;
            num_d = 12'd0;
        end
        if (state_d == S_IDLE) req_d = 1'b0;
        // A fresh request overrides whatever was pending or being acked.
        if (new_req) begin
            req_d = 1'b1;
            num_d = n_d;
        end
    end

    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            h_q           <= 12'd0;
            v_q           <= 12'd0;
            req_q         <= 1'b0;
            num_q         <= 12'd0;
            unf_q         <= 1'b0;
            x_o           <= 12'd0;
            y_o           <= 12'd0;
            de_o          <= 1'b0;
            hsync_o       <= SYNC_OFF;
            vsync_o       <= SYNC_OFF;
            frame_start_o <= 1'b0;
            running_o     <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            req_q         <= req_d;
            num_q         <= num_d;
            unf_q         <= unf_d;
            x_o           <= h_d;
            y_o           <= v_d;
            de_o          <= active_d && (h_d < H_ACT) && (v_d < V_ACT);
            hsync_o       <= (active_d && h_d >= HS_BEG && h_d < HS_END) ? SYNC_ON : SYNC_OFF;
            vsync_o       <= (active_d && v_d >= VS_BEG && v_d < VS_END) ? SYNC_ON : SYNC_OFF;
            frame_start_o <= active_d && (h_d == 12'd0) && (v_d == 12'd0);
            running_o     <= (state_d != S_IDLE);
        end
    end

    assign line_if.line_req = req_q;
    assign line_if.line_num = num_q;
    assign underflow_o      = unf_q;
endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: frame-position model plus directed scenarios,
// run against an active-high and an active-low sync instance in lockstep.
module tb_video_timing_ctrl;
    localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
    localparam int PF = 4;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;

    logic clk, rst, en, ack;
    int   withhold;

    logic        hs1, vs1, de1, fs1, unf1, run1;
    logic [11:0] x1, y1;
    logic        hs0, vs0, de0, fs0, unf0, run0;
    logic [11:0] x0, y0;

    video_timing_ctrl_if lif1();
    video_timing_ctrl_if lif0();
    assign lif1.line_ack = ack;
    assign lif0.line_ack = ack;

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1), .PREFETCH(PF)
    ) dut1 (
        .hdmi_clk(clk), .reset(rst), .enable_i(en),
        .hsync_o(hs1), .vsync_o(vs1), .de_o(de1), .x_o(x1), .y_o(y1),
        .frame_start_o(fs1), .underflow_o(unf1), .running_o(run1),
        .line_if(lif1)
    );

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(0), .PREFETCH(PF)
    ) dut0 (
        .hdmi_clk(clk), .reset(rst), .enable_i(en),
        .hsync_o(hs0), .vsync_o(vs0), .de_o(de0), .x_o(x0), .y_o(y0),
        .frame_start_o(fs0), .underflow_o(unf0), .running_o(run0),
        .line_if(lif0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: linear position within the frame while the raster is running.
    int pos, m_num, n;
    bit m_act, m_prime, m_stop, m_req, m_unf;

    initial begin
        pos = 0; m_num = 0; m_act = 0; m_prime = 0; m_stop = 0; m_req = 0; m_unf = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                pos = 0; m_num = 0; m_act = 0; m_prime = 0; m_stop = 0; m_req = 0; m_unf = 0;
            end else if (m_act) begin
                if (m_req && ack) m_req = 0;
                else if (m_req && (pos % HT) == HT - 1) begin m_req = 0; m_unf = 1; end
                if (m_stop && !en && pos == FT - 1) begin
                    m_act = 0; m_stop = 0; pos = 0; m_req = 0;
                end else begin
                    m_stop = !en;
                    pos = (pos + 1) % FT;
                    if ((pos % HT) == HT - PF) begin
                        n = (pos / HT + 1) % VT;
                        if (n < VA && !(m_stop && n == 0)) begin m_req = 1; m_num = n; end
                    end
                end
            end else if (m_prime) begin
                if (!en) begin m_prime = 0; m_req = 0; end
                else if (ack) begin m_prime = 0; m_act = 1; m_stop = 0; pos = 0; m_req = 0; end
            end else if (en) begin
                m_prime = 1; m_req = 1; m_num = 0;
            end
        end
    end

    int e_x, e_y;
    bit e_de, e_hs, e_vs, e_fs, e_run;

    initial begin
        forever begin
            @(negedge clk);
            e_x   = m_act ? pos % HT : 0;
            e_y   = m_act ? pos / HT : 0;
            e_de  = m_act && e_x < HA && e_y < VA;
            e_hs  = m_act && e_x >= HA + HFP && e_x < HA + HFP + HSW;
            e_vs  = m_act && e_y >= VA + VFP && e_y < VA + VFP + VSW;
            e_fs  = m_act && pos == 0;
            e_run = m_act || m_prime;
            check("x", x1, e_x);
            check("y", y1, e_y);
            check("de", de1, e_de);
            check("hsync", hs1, e_hs);
            check("vsync", vs1, e_vs);
            check("frame_start", fs1, e_fs);
            check("line_req", lif1.line_req, m_req);
            if (m_req) check("line_num", lif1.line_num, m_num);
            check("underflow", unf1, m_unf);
            check("running", run1, e_run);
            check("x_pol0", x0, e_x);
            check("y_pol0", y0, e_y);
            check("de_pol0", de0, e_de);
            check("hsync_pol0", hs0, !e_hs);
            check("vsync_pol0", vs0, !e_vs);
            check("frame_start_pol0", fs0, e_fs);
            check("line_req_pol0", lif0.line_req, m_req);
            check("underflow_pol0", unf0, m_unf);
            check("running_pol0", run0, e_run);
        end
    end

    initial begin
        ack = 1'b0;
        forever begin
            @(negedge clk);
            ack = lif1.line_req && (int'(lif1.line_num) != withhold);
        end
    end

    task automatic wait_xy(input int xx, input int yy);
        int k = 0;
        while (!(int'(x1) == xx && int'(y1) == yy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_xy: position (%0d,%0d) not reached, at (%0d,%0d)", xx, yy, x1, y1);
        end
    endtask

    task automatic wait_fs();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!fs1 && k < 300);
        if (!fs1) begin
            checks++;
            errors++;
            $display("FAIL wait_fs: no frame_start within 300 cycles, got 0 expected 1");
        end
    endtask

    int cnt;

    initial begin
        rst = 1'b1; en = 1'b0; withhold = -1;
        repeat (3) @(negedge clk);
        check("lit_reset_running", run1, 0);
        check("lit_reset_hsync", hs1, 0);
        check("lit_reset_hsync_pol0", hs0, 1);

        // Start-up
        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        check("lit_prime_req", lif1.line_req, 1);
        check("lit_prime_num", lif1.line_num, 0);
        check("lit_prime_fs", fs1, 0);
        @(negedge clk);
        check("lit_first_fs", fs1, 1);
        check("lit_first_de", de1, 1);
        check("lit_first_y", y1, 0);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!fs1 && cnt < 300);
        check("lit_frame_period", cnt, 98);

        // Timing decode and scheduling
        wait_xy(10, 0);
        check("lit_hsync_x10", hs1, 1);
        check("lit_hsync_pol0_x10", hs0, 0);
        check("lit_req_y0", lif1.line_req, 1);
        check("lit_num_y0", lif1.line_num, 1);
        wait_xy(7, 3);  check("lit_de_x7y3", de1, 1);
        wait_xy(8, 3);  check("lit_de_x8y3", de1, 0);
        wait_xy(10, 3); check("lit_noreq_y3", lif1.line_req, 0);
        wait_xy(0, 5);  check("lit_vsync_y5", vs1, 1);
        wait_xy(13, 5); check("lit_vsync_y5_end", vs1, 1);
        wait_xy(10, 6);
        check("lit_req_y6", lif1.line_req, 1);
        check("lit_num_y6", lif1.line_num, 0);
        wait_xy(0, 0);  check("lit_vsync_y0", vs1, 0);

        // Underflow
        withhold = 2;
        wait_xy(13, 1);
        check("lit_pending_req", lif1.line_req, 1);
        @(negedge clk);
        check("lit_unf_req_drop", lif1.line_req, 0);
        check("lit_unf_set", unf1, 1);
        check("lit_unf_de", de1, 1);
        wait_xy(7, 2); check("lit_unf_de_x7", de1, 1);
        withhold = -1;
        wait_xy(0, 0); check("lit_unf_sticky", unf1, 1);
        withhold = 3;
        wait_xy(11, 2);
        check("lit_pending_req3", lif1.line_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check("lit_rst_unf", unf1, 0);
        check("lit_rst_req", lif1.line_req, 0);
        rst = 1'b0; withhold = -1;

        // Reset mid-frame
        wait_fs();
        wait_xy(5, 2);
        rst = 1'b1;
        @(negedge clk);
        check("lit_midrst_x", x1, 0);
        check("lit_midrst_de", de1, 0);
        check("lit_midrst_running", run1, 0);

        // Enable withdrawn while priming
        withhold = 0; rst = 1'b0;
        @(negedge clk);
        check("lit_prime2_req", lif1.line_req, 1);
        en = 1'b0;
        @(negedge clk);
        check("lit_abort_req", lif1.line_req, 0);
        check("lit_abort_running", run1, 0);
        withhold = -1; en = 1'b1;

        // Stop at frame end
        wait_fs();
        wait_xy(3, 1); en = 1'b0;
        wait_xy(10, 6);
        check("lit_stop_noreq", lif1.line_req, 0);
        check("lit_stop_running", run1, 1);
        wait_xy(13, 6);
        @(negedge clk);
        check("lit_idle_running", run1, 0);
        check("lit_idle_hsync", hs1, 0);
        check("lit_idle_fs", fs1, 0);
        repeat (3) @(negedge clk);

        // Re-enable during the last line of a stopping frame
        en = 1'b1;
        wait_fs();
        wait_xy(3, 1); en = 1'b0;
        wait_xy(3, 6); en = 1'b1;
        wait_xy(10, 6);
        check("lit_resume_req", lif1.line_req, 1);
        check("lit_resume_num", lif1.line_num, 0);
        wait_xy(13, 6);
        @(negedge clk);
        check("lit_resume_fs", fs1, 1);
        check("lit_resume_running", run1, 1);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
